// File: rtl/pmem_line_adapter_pkg.sv
// Shared LC-3b memory types: word, cache line and beat index, plus line/word helpers.
// The line adapter and its read assembler both import this package.
package lc3b_types;

   localparam int WORDS_PER_LINE   = 8;
   localparam int LINE_OFFSET_BITS = 4;

   typedef logic [15:0]                  lc3b_word;
   typedef logic [127:0]                 lc3b_line;
   typedef logic [2:0]                   lc3b_beat_idx;
   typedef logic [15:LINE_OFFSET_BITS]   lc3b_tag;

   // Word k of a line lives at bits [16k+15:16k]; {idx, 4'b0} keeps the offset 7 bits wide.
   function automatic lc3b_word line_word(input lc3b_line line, input lc3b_beat_idx idx);
      return line[{idx, 4'b0} +: 16];
   endfunction

   function automatic lc3b_word beat_addr(input lc3b_tag tag, input lc3b_beat_idx idx);
      return {tag, idx, 1'b0};
   endfunction

endpackage

// File: rtl/pmem_line_adapter_if.sv
// Bus bundles on both sides of the line adapter: line-granular arbiter port and the
// narrow word-wide main-memory port.
interface pmem_line_if;
   import lc3b_types::*;

   logic     pmem_read;
   logic     pmem_write;
   lc3b_word pmem_address;
   lc3b_line pmem_wdata;
   logic     pmem_resp;
   lc3b_line pmem_rdata;

   modport master (output pmem_read, pmem_write, pmem_address, pmem_wdata,
                   input  pmem_resp, pmem_rdata);
   modport slave  (input  pmem_read, pmem_write, pmem_address, pmem_wdata,
                   output pmem_resp, pmem_rdata);
endinterface

interface mem_word_if;
   import lc3b_types::*;

   logic     mem_req;
   logic     mem_we;
   lc3b_word mem_addr;
   lc3b_word mem_wdata;
   logic     mem_ready;
   logic     mem_rvalid;
   lc3b_word mem_rdata;

   modport master (output mem_req, mem_we, mem_addr, mem_wdata,
                   input  mem_ready, mem_rvalid, mem_rdata);
   modport slave  (input  mem_req, mem_we, mem_addr, mem_wdata,
                   output mem_ready, mem_rvalid, mem_rdata);
endinterface

// File: rtl/pmem_line_adapter_line_word_buffer.sv
// 128-bit read-assembly register: one indexed 16-bit write port and a synchronous clear.
module line_word_buffer
   import lc3b_types::*;
(
   input  logic         clk,
   input  logic         reset_n,
   input  logic         clear,
   input  logic         we,
   input  lc3b_beat_idx idx,
   input  lc3b_word     wdata,
   output lc3b_line     line
);

   // NOTE: this is a flop array rather than a RAM, so it takes the async reset and
   // pmem_rdata reads as zero straight out of reset.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         line <= '0;
      end else if (clear) begin
         line <= '0;
      end else if (we) begin
         line[{idx, 4'b0} +: 16] <= wdata;
      end
   end

endmodule

// File: rtl/pmem_line_adapter.sv
// Splits arbiter line reads/writes into eight 16-bit beats on the main-memory port and
// returns a one-cycle pmem_resp per completed line.
module pmem_line_adapter
   import lc3b_types::*;
(
   input  logic        clk,
   input  logic        reset_n,
   pmem_line_if.slave  line_bus,
   mem_word_if.master  word_bus
);

   typedef enum logic [2:0] {
      IDLE, RD_REQ, RD_WAIT, WR_REQ, DONE, RECOVER
   } state_t;

   state_t       state, state_next;
   lc3b_beat_idx k, k_next;
   lc3b_tag      tag;
   lc3b_line     wline;
   logic         start;
   logic         rd_start;
   logic         rd_store;
   logic         unused_offset;

   assign unused_offset = ^line_bus.pmem_address[LINE_OFFSET_BITS-1:0];

   // NOTE: sequential state uses non-blocking assignments so every flop samples the
   // pre-edge value of every other flop, independent of statement order.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state <= IDLE;
         k     <= '0;
         tag   <= '0;
         wline <= '0;
      end else begin
         state <= state_next;
         k     <= k_next;
         if (start) begin
            tag   <= line_bus.pmem_address[15:LINE_OFFSET_BITS];
            wline <= line_bus.pmem_wdata;
         end
      end
   end

   // NOTE: every signal driven here gets its default first, so no path can infer a latch.
   always_comb begin
      state_next = state;
      k_next     = k;
      start      = 1'b0;
      rd_start   = 1'b0;
      rd_store   = 1'b0;
      case (state)
         IDLE: begin
            k_next = '0;
            if (line_bus.pmem_write) begin
               start      = 1'b1;
               state_next = WR_REQ;
            end else if (line_bus.pmem_read) begin
               start      = 1'b1;
               rd_start   = 1'b1;
               state_next = RD_REQ;
            end
         end
         RD_REQ: begin
            if (word_bus.mem_ready) state_next = RD_WAIT;
         end
         RD_WAIT: begin
            if (word_bus.mem_rvalid) begin
               rd_store = 1'b1;
               if (k == lc3b_beat_idx'(WORDS_PER_LINE - 1)) begin
                  state_next = DONE;
               end else begin
                  k_next     = k + 3'd1;
                  state_next = RD_REQ;
               end
            end
         end
         WR_REQ: begin
            // Write beats are posted: acceptance alone retires the beat.
            if (word_bus.mem_ready) begin
               if (k == lc3b_beat_idx'(WORDS_PER_LINE - 1)) state_next = DONE;
               else                                         k_next     = k + 3'd1;
            end
         end
         DONE:    state_next = RECOVER;
         RECOVER: state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   line_word_buffer u_rd_buf (
      .clk     (clk),
      .reset_n (reset_n),
      .clear   (rd_start),
      .we      (rd_store),
      .idx     (k),
      .wdata   (word_bus.mem_rdata),
      .line    (line_bus.pmem_rdata)
   );

   assign word_bus.mem_req   = (state == RD_REQ) || (state == WR_REQ);
   assign word_bus.mem_we    = (state == WR_REQ);
   assign word_bus.mem_addr  = beat_addr(tag, k);
   assign word_bus.mem_wdata = line_word(wline, k);
   assign line_bus.pmem_resp = (state == DONE);

endmodule

// File: tb/tb_pmem_line_adapter.sv
// Self-checking bench for pmem_line_adapter: table-driven bursts, hand-written corner
// sequences and randomized bursts against a word-array memory model.
module tb_pmem_line_adapter;
   import lc3b_types::*;

   logic clk = 1'b0;
   logic reset_n = 1'b0;
   always #5 clk = ~clk;

   pmem_line_if line_bus();
   mem_word_if  word_bus();

   pmem_line_adapter dut (
      .clk      (clk),
      .reset_n  (reset_n),
      .line_bus (line_bus),
      .word_bus (word_bus)
   );

   int tests  = 0;
   int failed = 0;

   task automatic check(input string name, input logic [127:0] actual, input logic [127:0] expected);
      tests++;
      if (actual !== expected) begin
         failed++;
         $display("FAIL %s: got %h expected %h", name, actual, expected);
      end
   endtask

   // ---------------- memory model ----------------
   typedef struct {
      logic        we;
      logic [15:0] addr;
      logic [15:0] data;
   } beat_t;

   logic [15:0] memory [0:32767];
   beat_t       beat_log[$];
   int          ready_stall [8];
   int          rv_delay    [8];
   int          ready_used  [8];
   int          stray_req  = 0;
   bit          stray_rand = 1'b0;
   int          stab_err   = 0;
   logic        req_q, we_q;
   logic [15:0] addr_q, wdata_q;
   logic        rd_pending;
   logic [15:0] rd_addr;
   int          rd_wait;
   int          bidx;

   always @(negedge clk or negedge reset_n) begin
      if (!reset_n) begin
         word_bus.mem_ready  = 1'b0;
         word_bus.mem_rvalid = 1'b0;
         word_bus.mem_rdata  = '0;
         req_q      = 1'b0;
         rd_pending = 1'b0;
      end else begin
         // What happened at the posedge just past, given what we drove and saw before it.
         if (req_q && word_bus.mem_ready) begin
            if (we_q) begin
               beat_log.push_back('{1'b1, addr_q, wdata_q});
               memory[addr_q[15:1]] = wdata_q;
            end else begin
               beat_log.push_back('{1'b0, addr_q, 16'h0});
               rd_pending = 1'b1;
               rd_addr    = addr_q;
               rd_wait    = rv_delay[addr_q[3:1]];
            end
         end else if (req_q) begin
            if (!word_bus.mem_req || word_bus.mem_we !== we_q || word_bus.mem_addr !== addr_q ||
                (we_q && word_bus.mem_wdata !== wdata_q))
               stab_err++;
         end
         word_bus.mem_rvalid = 1'b0;
         if (rd_pending) begin
            if (rd_wait == 0) begin
               word_bus.mem_rvalid = 1'b1;
               word_bus.mem_rdata  = memory[rd_addr[15:1]];
               rd_pending = 1'b0;
            end else begin
               rd_wait--;
               word_bus.mem_rdata = 16'($urandom);
            end
         end else if (stray_req > 0 || (stray_rand && $urandom_range(0, 3) == 0)) begin
            word_bus.mem_rvalid = 1'b1;
            word_bus.mem_rdata  = 16'($urandom);
            if (stray_req > 0) stray_req--;
         end
         if (word_bus.mem_req) begin
            bidx = int'(word_bus.mem_addr[3:1]);
            if (ready_used[bidx] < ready_stall[bidx]) begin
               word_bus.mem_ready = 1'b0;
               ready_used[bidx]++;
            end else begin
               word_bus.mem_ready = 1'b1;
            end
         end else begin
            word_bus.mem_ready = 1'($urandom_range(0, 1));
         end
         req_q   = word_bus.mem_req;
         we_q    = word_bus.mem_we;
         addr_q  = word_bus.mem_addr;
         wdata_q = word_bus.mem_wdata;
      end
   end

   // ---------------- burst helpers ----------------
   lc3b_line last_rdata = '0;

   task automatic clear_stalls();
      for (int i = 0; i < 8; i++) begin
         ready_stall[i] = 0;
         rv_delay[i]    = 0;
      end
   endtask

   // Starts at an IDLE-state negedge (cycle 0); returns at the negedge where pmem_resp is seen.
   task automatic do_burst(input logic rd, input logic wr, input logic [15:0] addr,
                           input lc3b_line wd, output int lat, output lc3b_line rdata);
      beat_log.delete();
      for (int i = 0; i < 8; i++) ready_used[i] = 0;
      line_bus.pmem_read    = rd;
      line_bus.pmem_write   = wr;
      line_bus.pmem_address = addr;
      line_bus.pmem_wdata   = wd;
      lat   = -1;
      rdata = '0;
      for (int c = 1; c <= 400; c++) begin
         @(posedge clk);
         @(negedge clk);
         if (c == 1) check("first_req", word_bus.mem_req, 1'b1);
         if (c == 3) begin
            line_bus.pmem_address = 16'($urandom);
            line_bus.pmem_wdata   = {$urandom, $urandom, $urandom, $urandom};
         end
         if (line_bus.pmem_resp) begin
            lat   = c;
            rdata = line_bus.pmem_rdata;
            break;
         end
      end
      if (lat < 0) check("resp_timeout", 1'b0, 1'b1);
   endtask

   task automatic check_burst(input logic rd, input logic wr, input logic [15:0] addr,
                              input lc3b_line wd, input int exp_lat, input bit hold);
      lc3b_line    exp_line;
      lc3b_line    got_line;
      lc3b_line    held;
      logic [32:0] exp_b;
      int          lat;
      for (int k = 0; k < 8; k++) exp_line[k*16 +: 16] = memory[{addr[15:4], 3'(k)}];
      held = last_rdata;
      do_burst(rd, wr, addr, wd, lat, got_line);
      if (!hold) begin
         line_bus.pmem_read  = 1'b0;
         line_bus.pmem_write = 1'b0;
      end
      check("latency", lat, exp_lat);
      if (rd && !wr) begin
         check("rdata", got_line, exp_line);
         last_rdata = exp_line;
      end else begin
         check("rdata_held", got_line, held);
      end
      @(negedge clk);
      check("resp_one_cycle", line_bus.pmem_resp, 1'b0);
      check("recover_no_req", word_bus.mem_req, 1'b0);
      check("beat_count", beat_log.size(), 8);
      for (int k = 0; k < 8 && k < beat_log.size(); k++) begin
         exp_b = {wr, addr[15:4], 3'(k), 1'b0, (wr ? wd[k*16 +: 16] : 16'h0)};
         check($sformatf("beat%0d", k), {beat_log[k].we, beat_log[k].addr, beat_log[k].data}, exp_b);
      end
      @(negedge clk);
   endtask

   // ---------------- stimulus table ----------------
   typedef struct {
      logic        rd;
      logic        wr;
      logic [15:0] addr;
      logic [15:0] wbase;
      int          rs_beat, rs_cyc, rv_beat, rv_cyc;
      int          lat;
   } vec_t;

   vec_t vecs [7];

   initial begin
      lc3b_line wd;
      logic     rd, wr;
      logic [15:0] a;
      int       exp_lat;

      vecs[0] = '{1'b1, 1'b0, 16'h1234, 16'h0000, 0, 0, 0, 0, 17};
      vecs[1] = '{1'b0, 1'b1, 16'h8008, 16'h0100, 0, 0, 0, 0,  9};
      vecs[2] = '{1'b1, 1'b0, 16'h1234, 16'h0000, 2, 3, 5, 2, 22};
      vecs[3] = '{1'b0, 1'b1, 16'h4F0A, 16'h7700, 0, 2, 0, 0, 11};
      vecs[4] = '{1'b1, 1'b0, 16'hFFFF, 16'h0000, 7, 1, 0, 1, 19};
      vecs[5] = '{1'b1, 1'b1, 16'h2000, 16'hBE00, 0, 0, 0, 0,  9};
      vecs[6] = '{1'b0, 1'b1, 16'h8008, 16'h0C00, 4, 2, 3, 3, 11};

      for (int i = 0; i < 32768; i++) memory[i] = 16'(i * 7 + 3);
      for (int k = 0; k < 8; k++) memory[{12'h123, 3'(k)}] = 16'hA000 + 16'(k);
      clear_stalls();
      line_bus.pmem_read    = 1'b0;
      line_bus.pmem_write   = 1'b0;
      line_bus.pmem_address = '0;
      line_bus.pmem_wdata   = '0;

      repeat (3) @(negedge clk);
      check("rst_resp",  line_bus.pmem_resp, 1'b0);
      check("rst_req",   word_bus.mem_req, 1'b0);
      check("rst_we",    word_bus.mem_we, 1'b0);
      check("rst_addr",  word_bus.mem_addr, 16'h0);
      check("rst_wdata", word_bus.mem_wdata, 16'h0);
      check("rst_rdata", line_bus.pmem_rdata, 128'h0);
      reset_n = 1'b1;

      for (int i = 0; i < 7; i++) begin
         clear_stalls();
         if (vecs[i].rs_cyc > 0) ready_stall[vecs[i].rs_beat] = vecs[i].rs_cyc;
         if (vecs[i].rv_cyc > 0) rv_delay[vecs[i].rv_beat]    = vecs[i].rv_cyc;
         for (int k = 0; k < 8; k++) wd[k*16 +: 16] = vecs[i].wbase + 16'(k);
         check_burst(vecs[i].rd, vecs[i].wr, vecs[i].addr, wd, vecs[i].lat, 1'b0);
      end
      clear_stalls();

      // Request held past pmem_resp: next burst only after RECOVER and the IDLE sample.
      check_burst(1'b1, 1'b0, 16'h1230, '0, 17, 1'b1);
      check("held_idle_no_req", word_bus.mem_req, 1'b0);
      check_burst(1'b1, 1'b0, 16'h1230, '0, 17, 1'b0);

      // Stray rvalid while idle leaves the assembled line untouched.
      @(posedge clk);
      stray_req = 2;
      repeat (3) @(negedge clk);
      check("stray_rdata", line_bus.pmem_rdata, last_rdata);
      check("stray_no_req", word_bus.mem_req, 1'b0);

      // Reset during beat 4 of a write.
      line_bus.pmem_write   = 1'b1;
      line_bus.pmem_address = 16'h6A50;
      line_bus.pmem_wdata   = {$urandom, $urandom, $urandom, $urandom};
      for (int c = 1; c <= 5; c++) begin
         @(posedge clk);
         @(negedge clk);
      end
      check("mid_beat4_addr", word_bus.mem_addr, 16'h6A58);
      reset_n = 1'b0;
      #1;
      check("mid_rst_req",   word_bus.mem_req, 1'b0);
      check("mid_rst_resp",  line_bus.pmem_resp, 1'b0);
      check("mid_rst_rdata", line_bus.pmem_rdata, 128'h0);
      line_bus.pmem_write = 1'b0;
      repeat (2) @(negedge clk);
      check("mid_rst_hold_resp", line_bus.pmem_resp, 1'b0);
      reset_n    = 1'b1;
      last_rdata = '0;
      check_burst(1'b1, 1'b0, 16'h3C04, '0, 17, 1'b0);

      // Randomized bursts; latency from the stall rules, data from the memory array.
      stray_rand = 1'b1;
      for (int n = 0; n < 24; n++) begin
         wr = 1'($urandom_range(0, 1));
         rd = wr ? 1'($urandom_range(0, 1)) : 1'b1;
         a  = 16'($urandom_range(0, 15)) << 4 | 16'($urandom_range(0, 15)) | 16'h5000;
         wd = {$urandom, $urandom, $urandom, $urandom};
         exp_lat = wr ? 9 : 17;
         for (int k = 0; k < 8; k++) begin
            ready_stall[k] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0;
            rv_delay[k]    = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0;
            exp_lat += ready_stall[k] + (wr ? 0 : rv_delay[k]);
         end
         check_burst(rd, wr, a, wd, exp_lat, 1'b0);
      end
      stray_rand = 1'b0;

      check("stable_during_stall", stab_err, 0);
      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule

// File: doc/pmem_line_adapter.md
# pmem_line_adapter

Converts the arbiter's line-granular physical-memory requests into an 8-beat sequence of 16-bit word transfers on the narrow main-memory port. Sits directly downstream of the cache arbiter. Gathers read beats into a 128-bit line, or scatters a 128-bit write line into 8 word writes. Returns a single-cycle `pmem_resp` per completed line.

## Interface
Parameters:
- none; line geometry is fixed by the `lc3b_types` constants.

Ports:
- `clk`  in  1  system clock; all state changes on its rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `pmem_read`  in  1  line read request from the arbiter, held until `pmem_resp`.
- `pmem_write`  in  1  line write request from the arbiter, held until `pmem_resp`.
- `pmem_address`  in  16  byte address (`lc3b_word`); bits [3:0] are ignored.
- `pmem_wdata`  in  128  write line (`lc3b_line`); word k is bits [16k+15:16k].
- `pmem_resp`  out  1  one-cycle pulse: line transfer complete.
- `pmem_rdata`  out  128  assembled read line; valid while `pmem_resp`=1 and held until the next read starts.
- `mem_req`  out  1  word transfer request.
- `mem_we`  out  1  1 = write beat, 0 = read beat.
- `mem_addr`  out  16  word byte address `{line_tag[15:4], k[2:0], 1'b0}`.
- `mem_wdata`  out  16  write word k.
- `mem_ready`  in  1  memory accepts the beat this cycle when `mem_req`=1.
- `mem_rvalid`  in  1  read data valid.
- `mem_rdata`  in  16  read word.

## Operation
- **Reset.** While `reset_n`=0, asynchronously enter IDLE. All outputs go to 0, beat counter k=0, the line buffer clears, and the latched tag/data clear. A reset mid-burst abandons the burst and produces no `pmem_resp`.
- **IDLE.** Samples the request each cycle. On `pmem_write` (write wins if both are set), or on `pmem_read` alone:
  - latch `pmem_address[15:4]` and `pmem_wdata`;
  - set k=0;
  - go to WR_REQ or RD_REQ.
- **Latched inputs.** Upstream changes to address or data during a burst are ignored.
- **RD_REQ.** `mem_req`=1, `mem_we`=0. On `mem_ready` go to RD_WAIT. `mem_rvalid` in this state is ignored.
- **RD_WAIT.** `mem_req`=0. On `mem_rvalid`:
  - store `mem_rdata` into word k;
  - if k=7, go to DONE; otherwise k+1 and back to RD_REQ.
- **WR_REQ.** `mem_req`=1, `mem_we`=1, `mem_wdata` = latched word k. On `mem_ready`:
  - if k=7, go to DONE; otherwise k+1 and stay in WR_REQ.
  - Write beats are posted; there is no write acknowledge.
- **DONE.** `pmem_resp`=1 for exactly one cycle, then go to RECOVER.
- **RECOVER.** One cycle with requests not sampled, so a request still high in the cycle after `pmem_resp` does not restart a burst. Then go to IDLE.
- **Counter.** k is 3 bits and never wraps past 7 within a burst.
- **Stray data.** `mem_rvalid` outside RD_WAIT is ignored.

## Timing
- Request sampled in IDLE at cycle 0; first `mem_req` at cycle 1.
- Zero-wait memory (`mem_ready` always 1, `rvalid` one cycle after accept):
  - read: `pmem_resp` at cycle 17;
  - write: `pmem_resp` at cycle 9.
- Each stall cycle on `mem_ready` or `mem_rvalid` adds exactly one cycle.
- Minimum spacing between line requests: 2 idle cycles after `pmem_resp` (RECOVER, then IDLE sample).
- `mem_addr` and `mem_wdata` are stable while `mem_req`=1 and `mem_ready`=0.
- All outputs are registered or decoded from state only. There are no combinational paths from `mem_*` inputs to `mem_req`.

## Structure
- `lc3b_types` gains:
  - `lc3b_line` (logic [127:0]);
  - `WORDS_PER_LINE`=8;
  - `LINE_OFFSET_BITS`=4;
  - `lc3b_beat_idx` (logic [2:0]).
- The state enum stays local to the module.
- One sub-module: `line_word_buffer`, a 128-bit register with an indexed 16-bit write port and a clear input. It serves as the read assembler; write data uses a separate latched copy.

## Test plan
- **Read, zero-wait.** Read at 0x1234; memory returns 0xA000+k for word k. Expect:
  - `mem_addr` 0x1230, 0x1232 … 0x123E;
  - `pmem_resp` at cycle 17;
  - `pmem_rdata` = {0xA007,…,0xA000}.
- **Write, zero-wait.** Write at 0x8008 with line words 0x0100+k. Expect:
  - 8 write beats at 0x8000…0x800E carrying 0x0100…0x0107;
  - `pmem_resp` at cycle 9.
- **Read with stalls.** Hold `mem_ready`=0 for 3 cycles on beat 2 and delay `rvalid` by 2 on beat 5. Expect:
  - `pmem_resp` at cycle 22;
  - address and control stable during stalls.
- **Held request after completion.** Keep `pmem_read`=1 for 2 cycles after `pmem_resp`. Expect no new `mem_req` until IDLE re-samples: a second burst starts exactly 2 cycles after `pmem_resp`.
- **Reset mid-burst.** Assert `reset_n`=0 during beat 4 of a write. Expect immediately:
  - `mem_req`=0 and `pmem_resp`=0;
  - after release, a fresh read starts at beat 0.
- **Simultaneous and stray inputs.** `pmem_read`=`pmem_write`=1 gives a write burst and one `pmem_resp`. A `mem_rvalid` pulse in IDLE leaves `pmem_rdata` unchanged.
